// File: rtl/mem_stage_pkg.sv
// Shared MEM-stage types: FSM state, memory request and writeback payloads, opcodes.
// Used by mem_stage (optional MEM_ALIGN_CHECK_EN build) and by decode/EX.
package mem_stage_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned REG_W  = 5;
    localparam int unsigned OPC_W  = 6;

    localparam logic [OPC_W-1:0] OP_LW = 6'b100011;
    localparam logic [OPC_W-1:0] OP_SW = 6'b101011;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_e;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } mem_req_t;

    typedef struct packed {
        logic              regwrite;
        logic [REG_W-1:0]  rd;
        logic [DATA_W-1:0] data;
    } wb_t;

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory bus between the MEM stage (master) and the data memory (slave).
interface mem_stage_if;
    import mem_stage_pkg::*;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );

endinterface

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register: one-cycle valid pulse per retirement, payload held between retirements.
module mem_wb_reg
    import mem_stage_pkg::*;
(
    input  logic              CLOCK,
    input  logic              RESET,
    input  logic              retire,
    input  wb_t               wb_in,
    output logic              wb_valid,
    output logic              wb_RegWrite,
    output logic [REG_W-1:0]  wb_reg,
    output logic [DATA_W-1:0] wb_data
);

    logic wb_valid_q, wb_valid_d;
    wb_t  wb_q, wb_d;

    always_comb begin
        wb_valid_d = retire;
        wb_d       = wb_q;
        if (retire) begin
            wb_d = wb_in;
        end
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            wb_valid_q <= 1'b0;
            wb_q       <= '0;
        end else begin
            wb_valid_q <= wb_valid_d;
            wb_q       <= wb_d;
        end
    end

    assign wb_valid    = wb_valid_q;
    assign wb_RegWrite = wb_q.regwrite;
    assign wb_reg      = wb_q.rd;
    assign wb_data     = wb_q.data;

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: IDLE/WAIT FSM issuing variable-latency lw/sw requests and retiring into MEM/WB.
// Define MEM_ALIGN_CHECK_EN to reject misaligned lw/sw and expose align_err.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic              CLOCK,
    input  logic              RESET,
    input  logic              valid_in,
    input  logic              RegWrite_in,
    input  logic              MemtoReg_in,
    input  logic              MemWrite_in,
    input  logic [DATA_W-1:0] alu_result_in,
    input  logic [DATA_W-1:0] store_data_in,
    input  logic [REG_W-1:0]  dest_reg_in,
    output logic              stall,
    mem_stage_if.master       mem,
    output logic              wb_valid,
    output logic              wb_RegWrite,
    output logic [REG_W-1:0]  wb_reg,
    output logic [DATA_W-1:0] wb_data
`ifdef MEM_ALIGN_CHECK_EN
    ,
    output logic              align_err
`endif
);

    state_e           state_q, state_d;
    logic             mem_req_q, mem_req_d;
    mem_req_t         req_q, req_d;
    logic             load_q, load_d;
    logic             rw_q, rw_d;
    logic [REG_W-1:0] dest_q, dest_d;

    logic             is_mem_c;
    logic             retire_c;
    wb_t              wb_c;

`ifdef MEM_ALIGN_CHECK_EN
    logic align_err_q, align_err_d;
    logic misalign_c;
    assign misalign_c = (alu_result_in[1:0] != 2'b00);
`endif

    // MemtoReg with MemWrite counts as a store, so MemWrite alone decides direction.
    assign is_mem_c = MemtoReg_in | MemWrite_in;

    always_comb begin
        state_d   = state_q;
        mem_req_d = mem_req_q;
        req_d     = req_q;
        load_d    = load_q;
        rw_d      = rw_q;
        dest_d    = dest_q;
        retire_c  = 1'b0;
        wb_c      = '0;
`ifdef MEM_ALIGN_CHECK_EN
        align_err_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (valid_in) begin
                    if (!is_mem_c) begin
                        retire_c = 1'b1;
                        wb_c     = '{RegWrite_in, dest_reg_in, alu_result_in};
                    end
`ifdef MEM_ALIGN_CHECK_EN
                    else if (misalign_c) begin
                        retire_c    = 1'b1;
                        wb_c        = '{1'b0, dest_reg_in, DATA_W'(0)};
                        align_err_d = 1'b1;
                    end
`endif
                    else begin
                        state_d   = WAIT;
                        mem_req_d = 1'b1;
                        req_d     = '{MemWrite_in, alu_result_in, store_data_in};
                        load_d    = ~MemWrite_in;
                        rw_d      = RegWrite_in;
                        dest_d    = dest_reg_in;
                    end
                end
            end
            WAIT: begin
                // Request stays frozen until the ack; rdata is only trusted in the ack cycle.
                if (mem.mem_ack) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    req_d.we  = 1'b0;
                    retire_c  = 1'b1;
                    wb_c      = load_q ? '{rw_q, dest_q, mem.mem_rdata}
                                       : '{1'b0, dest_q, DATA_W'(0)};
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            state_q   <= IDLE;
            mem_req_q <= 1'b0;
            req_q     <= '0;
            load_q    <= 1'b0;
            rw_q      <= 1'b0;
            dest_q    <= '0;
`ifdef MEM_ALIGN_CHECK_EN
            align_err_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            mem_req_q <= mem_req_d;
            req_q     <= req_d;
            load_q    <= load_d;
            rw_q      <= rw_d;
            dest_q    <= dest_d;
`ifdef MEM_ALIGN_CHECK_EN
            align_err_q <= align_err_d;
`endif
        end
    end

    assign stall         = (state_q == WAIT);
    assign mem.mem_req   = mem_req_q;
    assign mem.mem_we    = req_q.we;
    assign mem.mem_addr  = req_q.addr;
    assign mem.mem_wdata = req_q.wdata;
`ifdef MEM_ALIGN_CHECK_EN
    assign align_err     = align_err_q;
`endif

    mem_wb_reg u_mem_wb_reg (
        .CLOCK       (CLOCK),
        .RESET       (RESET),
        .retire      (retire_c),
        .wb_in       (wb_c),
        .wb_valid    (wb_valid),
        .wb_RegWrite (wb_RegWrite),
        .wb_reg      (wb_reg),
        .wb_data     (wb_data)
    );

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios then random instruction mix
// against a transaction-level model of issue, wait, retire and reset behaviour.
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic        CLOCK = 1'b0;
    logic        RESET = 1'b1;
    logic        valid_in = 1'b0;
    logic        RegWrite_in = 1'b0, MemtoReg_in = 1'b0, MemWrite_in = 1'b0;
    logic [31:0] alu_result_in = '0, store_data_in = '0;
    logic [4:0]  dest_reg_in = '0;
    logic        stall, wb_valid, wb_RegWrite;
    logic [4:0]  wb_reg;
    logic [31:0] wb_data;
`ifdef MEM_ALIGN_CHECK_EN
    logic        align_err;
`endif

    mem_stage_if bus();

    mem_stage u_dut (
        .CLOCK         (CLOCK),
        .RESET         (RESET),
        .valid_in      (valid_in),
        .RegWrite_in   (RegWrite_in),
        .MemtoReg_in   (MemtoReg_in),
        .MemWrite_in   (MemWrite_in),
        .alu_result_in (alu_result_in),
        .store_data_in (store_data_in),
        .dest_reg_in   (dest_reg_in),
        .stall         (stall),
        .mem           (bus),
        .wb_valid      (wb_valid),
        .wb_RegWrite   (wb_RegWrite),
        .wb_reg        (wb_reg),
        .wb_data       (wb_data)
`ifdef MEM_ALIGN_CHECK_EN
        ,
        .align_err     (align_err)
`endif
    );

    always #5 CLOCK = ~CLOCK;

    int vectors = 0;
    int miscompares = 0;

    // Model of the architecturally visible writeback: last retired values, pulse flag.
    logic        e_wbv = 1'b0, e_wbrw = 1'b0, e_alerr = 1'b0;
    logic [4:0]  e_wbreg = '0;
    logic [31:0] e_wbdata = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check(input string tag, input bit e_stall, input bit e_req,
                         input logic e_we, input logic [31:0] e_addr, input logic [31:0] e_wdata);
        chk({tag, ".stall"}, 32'(stall), 32'(e_stall));
        chk({tag, ".mem_req"}, 32'(bus.mem_req), 32'(e_req));
        if (e_req) begin
            chk({tag, ".mem_we"}, 32'(bus.mem_we), 32'(e_we));
            chk({tag, ".mem_addr"}, bus.mem_addr, e_addr);
            chk({tag, ".mem_wdata"}, bus.mem_wdata, e_wdata);
        end
        chk({tag, ".wb_valid"}, 32'(wb_valid), 32'(e_wbv));
        chk({tag, ".wb_RegWrite"}, 32'(wb_RegWrite), 32'(e_wbrw));
        chk({tag, ".wb_reg"}, 32'(wb_reg), 32'(e_wbreg));
        chk({tag, ".wb_data"}, wb_data, e_wbdata);
`ifdef MEM_ALIGN_CHECK_EN
        chk({tag, ".align_err"}, 32'(align_err), 32'(e_alerr));
`endif
    endtask

    // One or more idle cycles; acks while idle must be ignored.
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            valid_in = 1'b0;
            bus.mem_ack = 1'($urandom);
            bus.mem_rdata = $urandom;
            @(posedge CLOCK); #1;
            e_wbv = 1'b0;
            e_alerr = 1'b0;
            check("idle", 0, 0, 0, 0, 0);
        end
    endtask

    // Present one instruction in IDLE; for lw/sw, ack arrives in WAIT cycle number lat.
    task automatic exec(input string tag, input bit rw, input bit m2r, input bit mw,
                        input logic [31:0] alu, input logic [31:0] sd, input logic [4:0] rd,
                        input int lat, input logic [31:0] rdata);
        bit is_mem;
        valid_in = 1'b1;
        RegWrite_in = rw; MemtoReg_in = m2r; MemWrite_in = mw;
        alu_result_in = alu; store_data_in = sd; dest_reg_in = rd;
        bus.mem_ack = 1'($urandom);
        bus.mem_rdata = $urandom;
        @(posedge CLOCK); #1;
        e_alerr = 1'b0;
        is_mem = m2r | mw;
        if (!is_mem) begin
            e_wbv = 1'b1; e_wbrw = rw; e_wbreg = rd; e_wbdata = alu;
            check({tag, ".alu"}, 0, 0, 0, 0, 0);
        end
`ifdef MEM_ALIGN_CHECK_EN
        else if (alu[1:0] != 2'b00) begin
            e_wbv = 1'b1; e_wbrw = 1'b0; e_wbreg = rd; e_wbdata = '0; e_alerr = 1'b1;
            check({tag, ".misalign"}, 0, 0, 0, 0, 0);
        end
`endif
        else begin
            e_wbv = 1'b0;
            for (int k = 1; k <= lat; k++) begin
                check({tag, ".wait"}, 1, 1, mw, alu, sd);
                bus.mem_ack = (k == lat);
                bus.mem_rdata = (k == lat) ? rdata : $urandom;
                @(posedge CLOCK); #1;
            end
            e_wbv = 1'b1; e_wbreg = rd;
            e_wbrw = mw ? 1'b0 : rw;
            e_wbdata = mw ? 32'h0 : rdata;
            check({tag, ".retire"}, 0, 0, 0, 0, 0);
        end
        bus.mem_ack = 1'b0;
    endtask

    initial begin
        bus.mem_ack = 1'b0;
        bus.mem_rdata = '0;
        #1;
        check("reset", 0, 0, 0, 0, 0);
        chk("reset.mem_we", 32'(bus.mem_we), 32'h0);
        chk("reset.mem_addr", bus.mem_addr, 32'h0);
        chk("reset.mem_wdata", bus.mem_wdata, 32'h0);
        @(posedge CLOCK); #1;
        RESET = 1'b0;
        idle(2);

        exec("add", 1, 0, 0, 32'h0000_0007, 32'h0, 5'd5, 1, 32'h0);
        idle(1);
        exec("lw3", 1, 1, 0, 32'h0000_0010, 32'h0, 5'd8, 3, 32'hDEAD_BEEF);
        idle(1);
        exec("sw1", 0, 0, 1, 32'h0000_0020, 32'h0000_1234, 5'd3, 1, 32'h5555_AAAA);
        idle(1);
        exec("lwsw", 1, 1, 1, 32'h0000_0024, 32'h0000_0ABC, 5'd4, 2, 32'h7777_7777);
        idle(1);

        // Reset in the second WAIT cycle of a load, late ack after release.
        valid_in = 1'b1; RegWrite_in = 1'b1; MemtoReg_in = 1'b1; MemWrite_in = 1'b0;
        alu_result_in = 32'h0000_0040; dest_reg_in = 5'd9;
        @(posedge CLOCK); #1;
        e_wbv = 1'b0;
        check("rstwait.w1", 1, 1, 0, 32'h0000_0040, store_data_in);
        @(posedge CLOCK); #1;
        RESET = 1'b1;
        #1;
        e_wbv = 1'b0; e_wbrw = 1'b0; e_wbreg = '0; e_wbdata = '0;
        check("rstwait.reset", 0, 0, 0, 0, 0);
        valid_in = 1'b0;
        @(negedge CLOCK);
        RESET = 1'b0;
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'hBAD0_BAD0;
        @(posedge CLOCK); #1;
        check("rstwait.lateack", 0, 0, 0, 0, 0);
        bus.mem_ack = 1'b0;
        idle(1);

`ifdef MEM_ALIGN_CHECK_EN
        exec("lwmis", 1, 1, 0, 32'h0000_0013, 32'h0, 5'd6, 1, 32'h0);
        idle(1);
`endif

        exec("b2b.add1", 1, 0, 0, 32'h0000_0011, 32'h0, 5'd1, 1, 32'h0);
        exec("b2b.lw", 1, 1, 0, 32'h0000_0100, 32'h0, 5'd2, 1, 32'hCAFE_F00D);
        exec("b2b.add2", 1, 0, 0, 32'h0000_0022, 32'h0, 5'd7, 1, 32'h0);
        idle(1);

        for (int n = 0; n < 200; n++) begin
            int unsigned kind;
            kind = $urandom_range(0, 4);
            if (kind == 0) begin
                idle(int'($urandom_range(1, 2)));
            end else begin
                exec("rnd", 1'($urandom), kind == 2 || kind == 4, kind == 3 || kind == 4,
                     $urandom, $urandom, 5'($urandom),
                     int'($urandom_range(1, 4)), $urandom);
            end
        end
        idle(1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
